// File: rtl/booth_mult_r4.sv
// -----------------------------------------------------------------------------
// booth_mult_r4
//
// Sequential radix-4 modified Booth multiplier with valid/ready handshakes on
// both sides. Operands are captured in IDLE, one Booth iteration is performed
// per cycle in CALC, and the product is held in DONE until the consumer takes
// it. Signed and unsigned operands are handled uniformly by extending both
// operands to N+2 bits at capture: sign-extended or zero-extended as selected.
//
// Parameters
//   N          operand width in bits (even, >= 4)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operands present
//   in_ready   block accepts operands (high only in IDLE)
//   in_m       multiplicand, N bits
//   in_q       multiplier, N bits
//   in_signed  1 = two's-complement operands, 0 = unsigned operands
//   out_valid  product valid (high only in DONE)
//   out_ready  consumer accepts product
//   out_p      product, low 2N bits of the exact result
// -----------------------------------------------------------------------------
module booth_mult_r4 #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_m,
    input  logic [N-1:0]   in_q,
    input  logic           in_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_p
);

    // Extended operand width, iteration count, accumulator and counter widths.
    // The accumulator carries two guard bits above the extended multiplicand
    // so that A +/- 2M can never overflow.
    localparam int XW = N + 2;
    localparam int K  = XW / 2;
    localparam int AW = N + 4;
    localparam int CW = $clog2(K);

    if ((N % 2) != 0 || N < 4) begin : g_bad_width
        $error("booth_mult_r4: N must be even and at least 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [XW-1:0]   m_reg;
    logic [XW-1:0]   q_reg;
    logic            q_prev;
    logic [AW-1:0]   acc;
    logic [CW-1:0]   cnt;

    logic            last_iter;
    logic [AW-1:0]   m_ext;
    logic [AW-1:0]   pp;
    logic [AW-1:0]   sum;
    logic [AW-1:0]   acc_nxt;
    logic [XW-1:0]   q_nxt;
    logic            m_ext_bit;
    logic            q_ext_bit;

    assign last_iter = (cnt == CW'(K - 1));

    // Extension bit is the operand MSB in signed mode, zero in unsigned mode.
    assign m_ext_bit = in_signed & in_m[N-1];
    assign q_ext_bit = in_signed & in_q[N-1];

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and Moore outputs
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Booth partial-product selection and one radix-4 step
    // ------------------------------------------------------------------
    assign m_ext = {{(AW - XW){m_reg[XW-1]}}, m_reg};

    always_comb begin
        pp = '0;
        case ({q_reg[1:0], q_prev})
            3'b001, 3'b010: pp = m_ext;
            3'b011:         pp = m_ext << 1;
            3'b100:         pp = -(m_ext << 1);
            3'b101, 3'b110: pp = -m_ext;
            default:        pp = '0;
        endcase
    end

    assign sum = acc + pp;

    // {A, Q, q_prev} shifted arithmetically right by two: the two low bits of
    // the new sum move into the top of Q, and Q[1] becomes the next q_prev.
    assign acc_nxt = {{2{sum[AW-1]}}, sum[AW-1:2]};
    assign q_nxt   = {sum[1:0], q_reg[XW-1:2]};

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            m_reg  <= '0;
            q_reg  <= '0;
            q_prev <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            out_p  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m_reg  <= {{2{m_ext_bit}}, in_m};
                        q_reg  <= {{2{q_ext_bit}}, in_q};
                        q_prev <= 1'b0;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    acc    <= acc_nxt;
                    q_reg  <= q_nxt;
                    q_prev <= q_reg[1];
                    cnt    <= cnt + 1'b1;
                    // After K steps {A, Q} holds the full product; Q supplies
                    // the low N+2 bits and A the remaining N-2.
                    if (last_iter) begin
                        out_p <= {acc_nxt[N-3:0], q_nxt};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_r4.sv
// -----------------------------------------------------------------------------
// tb_booth_mult_r4
//
// Self-checking bench for booth_mult_r4 (N = 8). Directed vectors cover the
// boundary operands, back-pressure in DONE and a reset in the middle of CALC;
// a randomized run compares every product with a plain-arithmetic reference
// and measures back-to-back throughput.
// -----------------------------------------------------------------------------
module tb_booth_mult_r4;

    localparam int N = 8;
    localparam int K = (N + 2) / 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_m;
    logic [N-1:0]   in_q;
    logic           in_signed;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] out_p;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_cap = 0;
    int first_cap;

    booth_mult_r4 #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_m      (in_m),
        .in_q      (in_q),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Reference: exact product of the operands as integers, low 2N bits.
    function automatic logic [2*N-1:0] model(input logic [N-1:0] m,
                                             input logic [N-1:0] q,
                                             input bit s);
        longint a;
        longint b;
        longint p;
        a = s ? longint'($signed(m)) : longint'(m);
        b = s ? longint'($signed(q)) : longint'(q);
        p = a * b;
        return p[2*N-1:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction. Called #1 after a rising edge; returns #1 after the
    // edge that leaves DONE (consume=1) or while still in DONE (consume=0).
    task automatic txn(input logic [N-1:0] m, input logic [N-1:0] q,
                       input bit s, input logic [2*N-1:0] exp,
                       input bit chk_lat, input bit consume);
        int w;
        int lat;
        w = 0;
        while (in_ready !== 1'b1 && w < 50) begin
            @(posedge clk); #1; w++;
        end
        check("in_ready_before_capture", in_ready, 1'b1);
        in_m      = m;
        in_q      = q;
        in_signed = s;
        in_valid  = 1'b1;
        @(posedge clk);
        last_cap = cyc;
        #1;
        in_valid  = 1'b0;
        // Scramble operands during CALC; they must not affect the result.
        in_m      = N'($urandom);
        in_q      = N'($urandom);
        in_signed = 1'($urandom);
        check("in_ready_in_calc", in_ready, 1'b0);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        check("out_valid_seen", out_valid, 1'b1);
        if (chk_lat) check("latency", lat, K);
        check("product", out_p, exp);
        if (consume) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            check("out_valid_after_take", out_valid, 1'b0);
            check("in_ready_after_take", in_ready, 1'b1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_m      = '0;
        in_q      = '0;
        in_signed = 1'b0;
        out_ready = 1'b0;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_p", out_p, 16'h0000);

        // Boundary operands
        txn(8'h80, 8'h80, 1'b1, 16'h4000, 1'b1, 1'b1);
        txn(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1, 1'b1);
        txn(8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b1, 1'b1);
        txn(8'hFF, 8'h7F, 1'b1, 16'hFF81, 1'b0, 1'b1);
        txn(8'h00, 8'($urandom), 1'b1, 16'h0000, 1'b0, 1'b1);
        txn(8'h00, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1);

        // Back-pressure: product held for 10 cycles while in_valid toggles
        out_ready = 1'b0;
        txn(8'h5A, 8'hC3, 1'b1, 16'hEA8E, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid  = ~in_valid;
            in_m      = N'($urandom);
            in_q      = N'($urandom);
            in_signed = 1'($urandom);
            @(posedge clk); #1;
            check("hold_out_valid", out_valid, 1'b1);
            check("hold_out_p", out_p, 16'hEA8E);
            check("hold_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_in_ready", in_ready, 1'b1);
        check("release_out_valid", out_valid, 1'b0);
        check("idle_keeps_out_p", out_p, 16'hEA8E);
        @(posedge clk); #1;
        check("no_stray_capture", in_ready, 1'b1);

        // Reset during the third CALC iteration discards the transaction
        in_m      = 8'h12;
        in_q      = 8'h34;
        in_signed = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midcalc_rst_out_valid", out_valid, 1'b0);
        check("midcalc_rst_out_p", out_p, 16'h0000);
        check("midcalc_rst_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("no_pulse_after_rst", out_valid, 1'b0);
        end
        txn(8'd3, 8'd5, 1'b0, 16'h000F, 1'b1, 1'b1);

        // Random back-to-back transactions with out_ready held high
        out_ready = 1'b1;
        first_cap = 0;
        for (int i = 0; i < 1000; i++) begin
            logic [N-1:0] m;
            logic [N-1:0] q;
            bit           s;
            m = N'($urandom);
            q = N'($urandom);
            s = 1'($urandom_range(0, 1));
            txn(m, q, s, model(m, q, s), 1'b0, 1'b1);
            if (i == 0) first_cap = last_cap;
        end
        check("throughput", last_cap - first_cap, 999 * (K + 2));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
